fir_tap_sequencer: RTL and testbench

Upstream feeder for the FIR core's multiplier/adder ALU. Accepts one input sample per handshake, stores it in a circular delay line, and plays out the NTAPS (sample, coefficient) operand pairs for that output point, one pair per clock. The pairs drive the multiplier `a` and `b` inputs. The first/last markers tell the accumulator stage where each output point starts and ends. Coefficients are register-loaded through a simple write port.

---
 rtl/fir_tap_sequencer_if.sv | 30 +++
 rtl/fir_tap_sequencer.sv | 128 ++++++++++++
 tb/tb_fir_tap_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_sequencer_if.sv
// Handshake and operand bundle between the FIR tap sequencer, its upstream
// sample/coefficient source (master) and the multiplier/accumulator (slave side is the sequencer).
interface fir_tap_sequencer_if #(
    parameter int NTAPS = 16,
    parameter int DW    = 16,
    parameter int AW    = $clog2(NTAPS)
);
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [DW-1:0] coef_data;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          op_valid;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          op_first;
    logic          op_last;
    logic          busy;

    modport master (
        output coef_we, coef_addr, coef_data, in_valid, in_data,
        input  in_ready, op_valid, op_a, op_b, op_first, op_last, busy
    );

    modport slave (
        input  coef_we, coef_addr, coef_data, in_valid, in_data,
        output in_ready, op_valid, op_a, op_b, op_first, op_last, busy
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Circular delay line plus coefficient bank that plays NTAPS (x[n-k], h[k]) pairs per accepted sample.
// Optional history flush input is enabled by defining FIR_TAP_FLUSH_EN.
module fir_tap_sequencer #(
    parameter int NTAPS = 16,
    parameter int DW    = 16,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic clk,
    input  logic rst,
`ifdef FIR_TAP_FLUSH_EN
    input  logic flush,
`endif
    fir_tap_sequencer_if.slave bus
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [AW-1:0] LAST_TAP  = AW'(NTAPS - 1);
    localparam logic [AW:0]   NTAPS_EXT = (AW + 1)'(NTAPS);

    state_t        r_state;
    logic [DW-1:0] r_xBuf [NTAPS];
    logic [DW-1:0] r_h    [NTAPS];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_base;
    logic [AW-1:0] r_k;
    logic [DW-1:0] r_opA;
    logic [DW-1:0] r_opB;
    logic          r_opValid;
    logic          r_opFirst;
    logic          r_opLast;

    logic          w_idle;
    logic          w_inReady;
    logic          w_accept;
    logic          w_coefWrite;
    logic [AW-1:0] w_wrNext;
    logic [AW:0]   w_rdWide;
    logic [AW-1:0] w_rdIdx;

    assign w_idle = (r_state == S_IDLE);

`ifdef FIR_TAP_FLUSH_EN
    assign w_inReady = w_idle && !flush;
`else
    assign w_inReady = w_idle;
`endif

    assign w_accept    = w_inReady && bus.in_valid;
    assign w_coefWrite = w_idle && bus.coef_we && ({1'b0, bus.coef_addr} < NTAPS_EXT);
    assign w_wrNext    = (r_wrPtr == LAST_TAP) ? '0 : r_wrPtr + 1'b1;

    // (base - k) mod NTAPS without relying on NTAPS being a power of two
    always_comb begin
        w_rdWide = '0;
        if (r_base >= r_k) begin
            w_rdWide = {1'b0, r_base} - {1'b0, r_k};
        end else begin
            w_rdWide = {1'b0, r_base} + NTAPS_EXT - {1'b0, r_k};
        end
    end
    assign w_rdIdx = w_rdWide[AW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_wrPtr   <= '0;
            r_base    <= '0;
            r_k       <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_opValid <= 1'b0;
            r_opFirst <= 1'b0;
            r_opLast  <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                r_xBuf[i] <= '0;
                r_h[i]    <= '0;
            end
        end else begin
            if (w_coefWrite) begin
                r_h[bus.coef_addr] <= bus.coef_data;
            end
            case (r_state)
                S_IDLE: begin
                    r_opValid <= 1'b0;
                    r_opFirst <= 1'b0;
                    r_opLast  <= 1'b0;
`ifdef FIR_TAP_FLUSH_EN
                    if (flush) begin
                        for (int i = 0; i < NTAPS; i++) begin
                            r_xBuf[i] <= '0;
                        end
                        r_wrPtr <= '0;
                    end else
`endif
                    if (w_accept) begin
                        r_xBuf[r_wrPtr] <= bus.in_data;
                        r_base          <= r_wrPtr;
                        r_wrPtr         <= w_wrNext;
                        r_k             <= '0;
                        r_state         <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_opA     <= r_xBuf[w_rdIdx];
                    r_opB     <= r_h[r_k];
                    r_opValid <= 1'b1;
                    r_opFirst <= (r_k == '0);
                    r_opLast  <= (r_k == LAST_TAP);
                    if (r_k == LAST_TAP) begin
                        r_k     <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = w_inReady;
    assign bus.busy     = (r_state == S_RUN);
    assign bus.op_valid = r_opValid;
    assign bus.op_a     = r_opA;
    assign bus.op_b     = r_opB;
    assign bus.op_first = r_opFirst;
    assign bus.op_last  = r_opLast;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer (NTAPS=4): directed vector table, hand-written
// reset/flush sequences and randomized points checked against a sample-history model.
module tb_fir_tap_sequencer;
    localparam int NTAPS = 4;
    localparam int DW    = 16;

    typedef logic [DW-1:0] word_t;
    typedef word_t quad_t [NTAPS];
    typedef struct {
        word_t x;
        bit    hold;
        quad_t expA;
        quad_t expB;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
`ifdef FIR_TAP_FLUSH_EN
    logic flush = 1'b0;
`endif

    fir_tap_sequencer_if #(.NTAPS(NTAPS), .DW(DW)) bus ();

    fir_tap_sequencer #(.NTAPS(NTAPS), .DW(DW)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef FIR_TAP_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    word_t mHist[$];
    word_t mH [NTAPS];
    vec_t  vecs [8];
    quad_t zq = '{default: '0};

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
        end
    endtask

    // Reference model: newest accepted sample first, missing history reads as zero.
    task automatic modelReset();
        mHist.delete();
        for (int i = 0; i < NTAPS; i++) mH[i] = '0;
    endtask

    task automatic modelAccept(input word_t x, output quad_t a, output quad_t b);
        mHist.push_front(x);
        if (mHist.size() > NTAPS) void'(mHist.pop_back());
        for (int k = 0; k < NTAPS; k++) begin
            a[k] = (k < mHist.size()) ? mHist[k] : '0;
            b[k] = mH[k];
        end
    endtask

    task automatic writeCoef(input logic [1:0] addr, input word_t data);
        bus.coef_we   = 1'b1;
        bus.coef_addr = addr;
        bus.coef_data = data;
        mH[addr]      = data;
        @(negedge clk);
        bus.coef_we = 1'b0;
    endtask

    task automatic checkIdle();
        @(negedge clk);
        checkBit("idle_op_valid", bus.op_valid, 1'b0);
        checkBit("idle_op_last", bus.op_last, 1'b0);
        checkBit("idle_in_ready", bus.in_ready, 1'b1);
    endtask

    // Entered and left on a falling edge; the accept happens at the following rising edge.
    task automatic applyStimulus(input word_t x, input bit hold, input bit runCoef,
                                 input bit doCoef, input logic [1:0] cA, input word_t cD,
                                 input bit useTbl, input quad_t tA, input quad_t tB);
        quad_t eA;
        quad_t eB;
        int    waitCnt = 0;
        while (!bus.in_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!bus.in_ready) begin
            checkBit("in_ready_timeout", bus.in_ready, 1'b1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        if (doCoef) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = cA;
            bus.coef_data = cD;
            mH[cA]        = cD;
        end
        modelAccept(x, eA, eB);
        if (useTbl) begin
            eA = tA;
            eB = tB;
        end
        @(negedge clk);
        bus.coef_we = 1'b0;
        if (!hold) bus.in_valid = 1'b0;
        checkBit("run_in_ready", bus.in_ready, 1'b0);
        checkBit("run_busy", bus.busy, 1'b1);
        checkBit("bubble_op_valid", bus.op_valid, 1'b0);
        if (runCoef) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = 2'd0;
            bus.coef_data = 16'd9;
        end
        for (int k = 0; k < NTAPS; k++) begin
            @(negedge clk);
            bus.coef_we = 1'b0;
            checkBit("op_valid", bus.op_valid, 1'b1);
            checkOutput($sformatf("op_a[%0d]", k), bus.op_a, eA[k]);
            checkOutput($sformatf("op_b[%0d]", k), bus.op_b, eB[k]);
            checkBit("op_first", bus.op_first, k == 0);
            checkBit("op_last", bus.op_last, k == NTAPS - 1);
            checkBit("pair_in_ready", bus.in_ready, k == NTAPS - 1);
        end
    endtask

    initial begin
        quad_t eA;
        quad_t eB;

        vecs[0] = '{x: 16'd5,      hold: 1'b0, expA: '{16'd5, 16'd0, 16'd0, 16'd0},      expB: '{16'd1, 16'd2, 16'd3, 16'd4}};
        vecs[1] = '{x: 16'hFFF9,   hold: 1'b0, expA: '{16'hFFF9, 16'd5, 16'd0, 16'd0},   expB: '{16'd1, 16'd2, 16'd3, 16'd4}};
        vecs[2] = '{x: 16'd1,      hold: 1'b1, expA: '{16'd1, 16'hFFF9, 16'd5, 16'd0},   expB: '{16'd1, 16'd2, 16'd3, 16'd4}};
        vecs[3] = '{x: 16'd2,      hold: 1'b1, expA: '{16'd2, 16'd1, 16'hFFF9, 16'd5},   expB: '{16'd1, 16'd2, 16'd3, 16'd4}};
        vecs[4] = '{x: 16'd3,      hold: 1'b1, expA: '{16'd3, 16'd2, 16'd1, 16'hFFF9},   expB: '{16'd1, 16'd2, 16'd3, 16'd4}};
        vecs[5] = '{x: 16'd4,      hold: 1'b1, expA: '{16'd4, 16'd3, 16'd2, 16'd1},      expB: '{16'd1, 16'd2, 16'd3, 16'd4}};
        vecs[6] = '{x: 16'd5,      hold: 1'b1, expA: '{16'd5, 16'd4, 16'd3, 16'd2},      expB: '{16'd1, 16'd2, 16'd3, 16'd4}};
        vecs[7] = '{x: 16'd6,      hold: 1'b0, expA: '{16'd6, 16'd5, 16'd4, 16'd3},      expB: '{16'd1, 16'd2, 16'd3, 16'd4}};

        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        modelReset();

        @(negedge clk);
        checkBit("reset_op_valid", bus.op_valid, 1'b0);
        checkBit("reset_op_first", bus.op_first, 1'b0);
        checkBit("reset_op_last", bus.op_last, 1'b0);
        checkBit("reset_busy", bus.busy, 1'b0);
        checkOutput("reset_op_a", bus.op_a, '0);
        checkOutput("reset_op_b", bus.op_b, '0);
        rst = 1'b1;
        #1;
        checkBit("post_reset_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        writeCoef(2'd0, 16'd1);
        writeCoef(2'd1, 16'd2);
        writeCoef(2'd2, 16'd3);
        writeCoef(2'd3, 16'd4);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].x, vecs[i].hold, 1'b0, 1'b0, 2'd0, '0, 1'b1, vecs[i].expA, vecs[i].expB);
        end
        bus.in_valid = 1'b0;
        checkIdle();

        // Coefficient write during RUN is dropped; the same write in IDLE lands.
        applyStimulus(16'd3, 1'b0, 1'b1, 1'b0, 2'd0, '0, 1'b0, zq, zq);
        applyStimulus(16'd4, 1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b0, zq, zq);
        writeCoef(2'd0, 16'd9);
        applyStimulus(16'd5, 1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b0, zq, zq);
        applyStimulus(16'd6, 1'b0, 1'b0, 1'b1, 2'd3, 16'h0077, 1'b0, zq, zq);

        // Reset asserted while the second pair is on the outputs.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd11;
        modelAccept(16'd11, eA, eB);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_abort_op_a", bus.op_a, eA[1]);
        checkBit("pre_abort_op_valid", bus.op_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkBit("abort_op_valid", bus.op_valid, 1'b0);
        checkBit("abort_op_last", bus.op_last, 1'b0);
        checkBit("abort_busy", bus.busy, 1'b0);
        checkOutput("abort_op_a", bus.op_a, '0);
        checkOutput("abort_op_b", bus.op_b, '0);
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkBit("abort_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        for (int i = 0; i < NTAPS; i++) begin
            checkBit("abort_no_op_last", bus.op_last, 1'b0);
            checkBit("abort_no_op_valid", bus.op_valid, 1'b0);
            @(negedge clk);
        end
        applyStimulus(16'd2, 1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1,
                      '{16'd2, 16'd0, 16'd0, 16'd0}, '{16'd0, 16'd0, 16'd0, 16'd0});
        checkIdle();

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                writeCoef(2'($urandom_range(0, 3)), word_t'($urandom));
            end
            if ($urandom_range(0, 1) == 0) checkIdle();
            applyStimulus(word_t'($urandom), 1'b0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                          word_t'($urandom), 1'b0, zq, zq);
        end
        checkIdle();

`ifdef FIR_TAP_FLUSH_EN
        applyStimulus(16'd1, 1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b0, zq, zq);
        applyStimulus(16'd2, 1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b0, zq, zq);
        applyStimulus(16'd3, 1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b0, zq, zq);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd99;
        #1;
        checkBit("flush_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        checkBit("flush_busy", bus.busy, 1'b0);
        @(negedge clk);
        checkBit("flush_op_valid", bus.op_valid, 1'b0);
        mHist.delete();
        applyStimulus(16'd8, 1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b0, zq, zq);
        checkIdle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
